// File: rtl/sram_pkg.sv
// Shared types and constants for the off-chip SRAM port.
// Bus geometry and the access-state encoding.
package sram_pkg;
  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_TURN
  } sram_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Searches from last+1, wrapping, for the first request.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  iReq,
  input  logic [IW-1:0] iLast,
  output logic [N-1:0]  oGnt,
  output logic [IW-1:0] oIdx,
  output logic          oAny
);

  logic [IW-1:0] k;

  // First requester after the last winner, wrapping modulo N
  always_comb begin
    oGnt = '0;
    oIdx = '0;
    oAny = 1'b0;
    k    = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(iLast) + i) % N);
      if (!oAny && iReq[k]) begin
        oAny    = 1'b1;
        oIdx    = k;
        oGnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter for the shared off-chip SRAM port.
// Registered bus, turnaround on direction change.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = SRAM_AW,
  parameter int DW      = SRAM_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    iReq,
  input  logic [NUM_REQ-1:0]    iWe,
  input  logic [NUM_REQ*AW-1:0] iAddr,
  input  logic [NUM_REQ*DW-1:0] iWdata,
  output logic [NUM_REQ-1:0]    oGnt,
  output logic [NUM_REQ-1:0]    oRvalid,
  output logic [DW-1:0]         oRdata,
  output logic                  oBusy,
  output logic [AW-1:0]         oSRAM_ADDR,
  inout  wire  [DW-1:0]         oSRAM_DQ,
  output logic                  oSRAM_OE_N,
  output logic                  oSRAM_WE_N,
  output logic                  oSRAM_CE_N,
  output logic                  oSRAM_LB_N,
  output logic                  oSRAM_UB_N
);

  localparam int IW = $clog2(NUM_REQ);

  sram_state_t      state_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    rd_idx_q;
  logic [DW-1:0]    wdata_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               cand_we;
  logic               blocked;
  logic               grant;

  logic [AW-1:0] addr_arr  [NUM_REQ];
  logic [DW-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = iAddr[g*AW +: AW];
    assign wdata_arr[g] = iWdata[g*DW +: DW];
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .iReq  (iReq),
    .iLast (last_q),
    .oGnt  (arb_gnt),
    .oIdx  (arb_idx),
    .oAny  (arb_any)
  );

  assign cand_we = iWe[arb_idx];

  // Withhold the grant when it would flip the bus direction
  always_comb begin
    blocked = 1'b0;
    if (arb_any) begin
      unique case (1'b1)
        state_q == S_READ:  blocked = cand_we;
        state_q == S_WRITE: blocked = !cand_we;
        default:            blocked = 1'b0;
      endcase
    end
  end

  assign grant = arb_any && !blocked;
  assign oGnt  = grant ? arb_gnt : '0;
  assign oBusy = (state_q == S_READ) || (state_q == S_WRITE);

  assign oSRAM_DQ   = oSRAM_WE_N ? {DW{1'bz}} : wdata_q;
  assign oSRAM_CE_N = 1'b0;
  assign oSRAM_LB_N = 1'b0;
  assign oSRAM_UB_N = 1'b0;

  // Access FSM: registers the granted access onto the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= IW'(NUM_REQ - 1);
      rd_idx_q   <= '0;
      wdata_q    <= '0;
      oSRAM_ADDR <= '0;
      oSRAM_OE_N <= 1'b1;
      oSRAM_WE_N <= 1'b1;
    end else if (grant) begin
      last_q     <= arb_idx;
      rd_idx_q   <= arb_idx;
      wdata_q    <= wdata_arr[arb_idx];
      oSRAM_ADDR <= addr_arr[arb_idx];
      oSRAM_OE_N <= cand_we;
      oSRAM_WE_N <= !cand_we;
      state_q    <= cand_we ? S_WRITE : S_READ;
    end else begin
      oSRAM_OE_N <= 1'b1;
      oSRAM_WE_N <= 1'b1;
      state_q    <= blocked ? S_TURN : S_IDLE;
    end
  end

  // Read return: sample DQ at the end of the read cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oRvalid <= '0;
      oRdata  <= '0;
    end else if (state_q == S_READ) begin
      oRvalid <= NUM_REQ'(1) << rd_idx_q;
      oRdata  <= oSRAM_DQ;
    end else begin
      oRvalid <= '0;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model plus
// a transaction-level reference of the arbitration rules.
module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  we = '0;
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_wd   [N];
  logic [N*AW-1:0] addr_f;
  logic [N*DW-1:0] wd_f;

  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] sa;
  wire  [DW-1:0] dq;
  logic oe_n, we_n, ce_n, lb_n, ub_n;

  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] ref_mem [4096];

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: direction on the bus this cycle
  // (0 none, 1 read, 2 write) and expected pins
  int            m_last;
  int            m_bus;
  int            mg;
  logic          e_we_n, e_oe_n;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd, p_rd;
  logic [N-1:0]  e_rv;
  bit            p_v;
  int            p_idx;

  logic [N-1:0]  obs_gnt, obs_rv;
  logic [DW-1:0] obs_rd;
  logic          obs_oe, obs_we;

  always #5 clk = ~clk;

  always_comb begin
    addr_f = '0;
    wd_f   = '0;
    for (int k = 0; k < N; k++) begin
      addr_f[k*AW +: AW] = r_addr[k];
      wd_f[k*DW +: DW]   = r_wd[k];
    end
  end

  sram_arbiter #(
    .NUM_REQ(N), .AW(AW), .DW(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iReq       (req),
    .iWe        (we),
    .iAddr      (addr_f),
    .iWdata     (wd_f),
    .oGnt       (gnt),
    .oRvalid    (rvalid),
    .oRdata     (rdata),
    .oBusy      (busy),
    .oSRAM_ADDR (sa),
    .oSRAM_DQ   (dq),
    .oSRAM_OE_N (oe_n),
    .oSRAM_WE_N (we_n),
    .oSRAM_CE_N (ce_n),
    .oSRAM_LB_N (lb_n),
    .oSRAM_UB_N (ub_n)
  );

  // Asynchronous SRAM: drives DQ while OE_N low
  assign dq = (oe_n == 1'b0) ? mem[sa[11:0]] : 16'bz;

  always @(posedge clk)
    if (we_n == 1'b0) mem[sa[11:0]] <= dq;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bench and DUT must never drive DQ together
  always @(negedge clk) begin
    n_chk++;
    assert (!(oe_n === 1'b0 && we_n === 1'b0)) else begin
      n_fail++;
      $error("FAIL contention: oe_n %b we_n %b", oe_n, we_n);
    end
  end

  task automatic model_reset();
    m_last = N - 1;
    m_bus  = 0;
    mg     = -1;
    e_we_n = 1'b1;
    e_oe_n = 1'b1;
    e_addr = '0;
    e_wd   = '0;
    e_rd   = '0;
    e_rv   = '0;
    p_v    = 1'b0;
    p_idx  = 0;
    p_rd   = '0;
  endtask

  // One clock: check pins at negedge, then step the reference
  task automatic cyc();
    int cand;
    int k;
    int dir;
    bit blk;
    logic [N-1:0] eg;
    @(negedge clk);
    obs_gnt = gnt;
    obs_rv  = rvalid;
    obs_rd  = rdata;
    obs_oe  = oe_n;
    obs_we  = we_n;
    cand = -1;
    for (int i = 1; i <= N; i++) begin
      k = (m_last + i) % N;
      if (cand < 0 && req[k]) cand = k;
    end
    dir = 0;
    if (cand >= 0) dir = we[cand] ? 2 : 1;
    blk = (cand >= 0) && (m_bus != 0) && (dir != m_bus);
    eg  = (cand >= 0 && !blk) ? N'(1 << cand) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_bus != 0));
    chk("we_n", 32'(we_n), 32'(e_we_n));
    chk("oe_n", 32'(oe_n), 32'(e_oe_n));
    chk("addr", 32'(sa), 32'(e_addr));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    if (e_rv != 0) chk("rdata", 32'(rdata), 32'(e_rd));
    if (e_we_n == 1'b0) chk("dq_wr", 32'(dq), 32'(e_wd));
    mg = (eg != 0) ? cand : -1;
    e_rv = p_v ? N'(1 << p_idx) : '0;
    e_rd = p_rd;
    p_v  = 1'b0;
    if (mg >= 0) begin
      m_last = mg;
      e_addr = r_addr[mg];
      if (we[mg]) begin
        e_we_n = 1'b0;
        e_oe_n = 1'b1;
        e_wd   = r_wd[mg];
        ref_mem[r_addr[mg][11:0]] = r_wd[mg];
        m_bus  = 2;
      end else begin
        e_we_n = 1'b1;
        e_oe_n = 1'b0;
        p_v    = 1'b1;
        p_idx  = mg;
        p_rd   = ref_mem[r_addr[mg][11:0]];
        m_bus  = 1;
      end
    end else begin
      e_we_n = 1'b1;
      e_oe_n = 1'b1;
      m_bus  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ng, nw, w;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'h3c5a;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h3c5a;
    end
    for (int k = 0; k < N; k++) begin
      r_addr[k] = '0;
      r_wd[k]   = '0;
    end
    model_reset();
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(sa), 0);
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_we_n", 32'(we_n), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three readers held: rotation 0,1,2,0
    r_addr[0] = 20'h00010;
    r_addr[1] = 20'h00020;
    r_addr[2] = 20'h00030;
    req = 3'b111;
    we  = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_order", 32'(obs_gnt), 32'(1 << (i % 3)));
    end
    req = '0;
    repeat (3) cyc();

    // Write then read of the same word: one turnaround
    r_addr[0] = 20'h00100;
    r_wd[0]   = 16'hABCD;
    req = 3'b001;
    we  = 3'b001;
    cyc();
    chk("t2_wgnt", 32'(obs_gnt), 1);
    r_addr[1] = 20'h00100;
    req = 3'b010;
    we  = 3'b000;
    cyc();
    chk("t2_block", 32'(obs_gnt), 0);
    chk("t2_wr_bus", 32'(obs_we), 0);
    cyc();
    chk("t2_turn_gnt", 32'(obs_gnt), 2);
    chk("t2_turn_oe", 32'(obs_oe), 1);
    chk("t2_turn_we", 32'(obs_we), 1);
    req = '0;
    cyc();
    chk("t2_rd_bus", 32'(obs_oe), 0);
    cyc();
    chk("t2_rvalid", 32'(obs_rv), 2);
    chk("t2_rdata", 32'(obs_rd), 32'h0000ABCD);

    // Streamed writes from one requester, no bubbles
    ng = 0;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      r_addr[2] = AW'(i);
      r_wd[2]   = DW'(i);
      req = 3'b100;
      we  = 3'b100;
      cyc();
      if (obs_gnt == 3'b100) ng++;
      if (obs_we == 1'b0) nw++;
    end
    req = '0;
    cyc();
    if (obs_we == 1'b0) nw++;
    chk("t3_grants", 32'(ng), 40);
    chk("t3_we_cycles", 32'(nw), 40);
    cyc();

    // Continuous reader vs. intermittent writer
    r_addr[1] = 20'h00200;
    req = 3'b010;
    we  = 3'b000;
    repeat (2) cyc();
    for (int it = 0; it < 6; it++) begin
      r_addr[0] = AW'(20'h00300 + it);
      r_wd[0]   = 16'($urandom);
      req[0] = 1'b1;
      we[0]  = 1'b1;
      w = 0;
      do begin
        cyc();
        w++;
      end while (!obs_gnt[0] && w < 5);
      chk("t4_latency", 32'(w), (w <= 2) ? 32'(w) : 2);
      req[0] = 1'b0;
      repeat (3) cyc();
    end
    req = '0;
    repeat (3) cyc();

    // Reset while a read is on the bus
    r_addr[0] = 20'h00010;
    req = 3'b001;
    we  = 3'b000;
    cyc();
    chk("t5_gnt", 32'(obs_gnt), 1);
    req = '0;
    chk("t5_rd_on", 32'(oe_n), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_oe_rel", 32'(oe_n), 1);
    chk("t5_we_rel", 32'(we_n), 1);
    chk("t5_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    chk("t5_no_rv", 32'(rvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("t5_no_rv2", 32'(rvalid), 0);
    req = 3'b111;
    we  = 3'b000;
    cyc();
    chk("t5_first", 32'(obs_gnt), 1);
    req = '0;
    repeat (3) cyc();

    // Random traffic against the reference
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if (mg == k) begin
            if ($urandom_range(3) != 0) req[k] = 1'b0;
          end else if ($urandom_range(15) == 0) begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          req[k]    = 1'b1;
          we[k]     = 1'($urandom_range(1));
          r_addr[k] = AW'($urandom);
          r_wd[k]   = DW'($urandom);
        end
      end
      cyc();
    end
    req = '0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM port (20-bit address, active-low OE/WE, tristate DQ) between NUM_REQ requesters, e.g. frame capture writer, color_transform engine and display reader.
- Round-robin arbitration, one access per granted cycle, registered SRAM outputs.
- Inserts a bus-turnaround idle cycle on every read/write direction change.
- Sits between the processing engines and the top-level SRAM pins.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- AW, 20, SRAM address width.
- DW, 16, SRAM data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iReq  in  NUM_REQ  per-requester access request, held until granted.
- iWe  in  NUM_REQ  per-requester direction: 1 = write, 0 = read. Valid with iReq.
- iAddr  in  NUM_REQ*AW  flattened addresses. Requester k uses slice [k*AW +: AW].
- iWdata  in  NUM_REQ*DW  flattened write data. Requester k uses slice [k*DW +: DW].
- oGnt  out  NUM_REQ  one-hot grant (combinational). The access is accepted in the cycle oGnt[k]=1.
- oRvalid  out  NUM_REQ  one-hot, one-cycle pulse: read data for requester k is valid.
- oRdata  out  DW  read data, shared by all requesters, qualified by oRvalid.
- oBusy  out  1  an access is on the bus this cycle.
- oSRAM_ADDR  out  AW  registered address.
- oSRAM_DQ  inout  DW  driven with write data only while oSRAM_WE_N=0; high-Z otherwise.
- oSRAM_OE_N, oSRAM_WE_N  out  1  registered strobes.
- oSRAM_CE_N, oSRAM_LB_N, oSRAM_UB_N  out  1  tied 0.

Behaviour:
- Reset values:
  - oGnt=0, oRvalid=0, oRdata=0, oBusy=0, oSRAM_ADDR=0.
  - oSRAM_OE_N=1, oSRAM_WE_N=1, DQ high-Z.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first. state=S_IDLE.
- Arbitration (cycle t):
  - Candidate = first k with iReq[k]=1, searching from last+1 and wrapping modulo NUM_REQ.
  - oGnt[cand]=1 unless turnaround blocks it (see below). On grant, last<=cand.
- Issue latency:
  - Granted access is registered at the end of t and drives the SRAM bus during t+1.
  - Write at t+1: WE_N=0, OE_N=1, DQ=wdata.
  - Read at t+1: OE_N=0, WE_N=1, DQ high-Z.
  - Read data is sampled at the end of t+1 into oRdata. oRvalid[cand]=1 in t+2 (read latency 2 from grant).
- States:
  - S_IDLE: bus idle.
  - S_READ: read on bus.
  - S_WRITE: write on bus.
  - S_TURN: forced idle cycle.
  - Next state: the granted access type, else S_IDLE. If the candidate's direction differs from the access on the bus in cycle t (S_READ vs S_WRITE), the grant is withheld and next=S_TURN.
  - From S_TURN or S_IDLE, any direction may be granted.
- Back-to-back same-direction accesses: one per cycle, no bubbles.
- Fairness:
  - A requester holding iReq waits at most NUM_REQ-1 grants plus one turnaround per grant before it is served.
  - During a turnaround cycle the pointer does not advance, so the blocked candidate wins in the next cycle.
- Requester drops iReq before grant: no access, no state change.
- Requester keeps iReq high after grant: treated as a new request, arbitrated again.
- oBusy=1 in S_READ and S_WRITE.
- Asynchronous reset mid-access: bus released immediately. A pending oRvalid is never issued. Pointer returns to NUM_REQ-1.

Decomposition:
- Package sram_pkg:
  - SRAM_AW=20, SRAM_DW=16.
  - Enum sram_state_t {S_IDLE, S_READ, S_WRITE, S_TURN}.
- Sub-module rr_arbiter (parameter N): combinational round-robin pick from iReq and last pointer; outputs one-hot grant and encoded index.
- FSM, registered bus, turnaround logic and read-return pipeline stay in sram_arbiter.

Test Plan:
- After reset, iReq=3'b111, iWe=3'b000, addrs 0x00010/0x00020/0x00030 held → grants in order 0,1,2,0 on consecutive cycles. oSRAM_ADDR follows one cycle later. oRvalid pulses 2 cycles after each grant, with oRdata equal to the SRAM model contents.
- Req0 writes 0xABCD to 0x00100, then req1 reads 0x00100 in the next cycle → one S_TURN cycle (oGnt=0, OE_N=WE_N=1). Read granted one cycle later; oRvalid[1] with oRdata=0xABCD.
- Only req2 requests, 40 consecutive writes to addr 0..39 with data=addr → 40 grants in 40 cycles. WE_N low for 40 cycles; DQ driven only in those cycles (SRAM model checks for contention).
- Req1 reads continuously while req0 alternates write requests → req0 granted within 2 cycles every time. No starvation; a turnaround appears at every direction change.
- rst_n asserted 1 cycle after a read grant → OE_N=1 and DQ high-Z immediately. No oRvalid. First grant after release goes to req0.
- Concurrent read/write SRAM bus check throughout all tests: assertion that the bench model and the DUT never both drive DQ.
